bram_load_seq: RTL and testbench
================================

# bram_load_seq

Host-side load sequencer that sits directly upstream of the BRAM controller in the ASIC tester. It accepts a byte stream from the host link and decodes a command byte. It assembles 128- or 256-bit payloads MSB-first and issues exactly one TEMPLATE_WRITE, FF_WRITE or INPUT_WRITE strobe to the controller, then waits for the controller's READY before reporting completion.

## Interface
- TIMEOUT, 1024: max idle cycles between payload bytes before abort; 0 disables the timeout.
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- RX_DATA  in  8  host byte.
- RX_VALID  in  1  RX_DATA valid.
- RX_READY  out  1  sequencer accepts a byte this cycle; a byte transfers on an edge where RX_VALID & RX_READY.
- BRAM_READY  in  1  controller READY.
- TEMPLATE_WRITE, FF_WRITE, INPUT_WRITE  out  1 each  one-cycle write strobes to the controller.
- WRITE_DATA_0, WRITE_DATA_1  out  128 each  payload words to the controller.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when the controller has completed the write.
- ERR  out  1  one-cycle pulse on an aborted command.
- ERR_CODE  out  2  cause of the last ERR, held until the next ERR: 1 = bad opcode, 2 = timeout, 3 = checksum.

## Operation
- Command byte: bits[1:0] select the operation.
  - 01 = template write, 16 payload bytes.
  - 10 = FF write, 32 payload bytes.
  - 11 = input write, 16 payload bytes.
  - 00 with bits[7:2] = 0 is a NOP: consumed, no DONE, no ERR.
  - Any other value (bits[7:2] nonzero) → ERR with ERR_CODE = 1; the sequencer stays in IDLE.
- Accepting a valid command clears WRITE_DATA_0/1 to 0 and resets the byte counter.
- Payload shifting, MSB first:
  - Bytes 0–15 shift into WRITE_DATA_0: WRITE_DATA_0 <= {WRITE_DATA_0[119:0], RX_DATA}.
  - Bytes 16–31 (FF write only) shift the same way into WRITE_DATA_1.
- States:
  - IDLE: RX_READY = 1.
  - PAYLOAD: RX_READY = 1.
  - CHECK (macro only): RX_READY = 1.
  - ISSUE: RX_READY = 0.
  - GAP: RX_READY = 0.
  - WAIT_RDY: RX_READY = 0.
- Transitions:
  - IDLE → PAYLOAD on a valid command.
  - PAYLOAD → ISSUE on the last payload byte (→ CHECK when the macro is set).
  - ISSUE: waits while BRAM_READY = 0. When BRAM_READY = 1, asserts the selected strobe for exactly one cycle, then → GAP.
  - GAP → WAIT_RDY unconditionally after one cycle; BRAM_READY is ignored here, covering the controller's drop latency.
  - WAIT_RDY → IDLE when BRAM_READY = 1, pulsing DONE in that cycle.
- WRITE_DATA_0/1 are stable from entry to ISSUE until the next valid command is accepted.
- Timeout counter:
  - Counts cycles in PAYLOAD/CHECK with no byte accepted; resets on each accepted byte.
  - On reaching TIMEOUT: ERR with ERR_CODE = 2, → IDLE, no strobe.
- RST_N asserted mid-command aborts it immediately with no strobe, DONE or ERR.

## Timing
- Reset values:
  - RX_READY, all strobes, BUSY, DONE, ERR = 0.
  - ERR_CODE = 0; WRITE_DATA_0/1 = 0; state = IDLE.
  - RX_READY rises in the first clock after RST_N deasserts.
- Last payload byte accepted at edge N:
  - State is ISSUE during cycle N+1; the strobe is high in N+1 if BRAM_READY = 1.
  - GAP occupies cycle N+2.
  - Earliest DONE is in cycle N+3.
- A new command byte can be accepted in the cycle after DONE.
- All outputs are registered.
- Strobes are mutually exclusive and never high outside ISSUE.

## Configuration
- BRAM_LOAD_SEQ_CHECKSUM_EN defined:
  - One extra byte follows the payload, in state CHECK. It must equal the XOR of the command byte and all payload bytes.
  - Mismatch: ERR with ERR_CODE = 3, → IDLE, no strobe.
  - The timeout also applies in CHECK.
- Not defined: there is no CHECK state, ISSUE follows the last payload byte directly, and ERR_CODE 3 never occurs.

## Test plan
- Template write: bytes 0x01, then 01 23 FE ED DE AD BE EF ×2, with BRAM_READY = 1 → WRITE_DATA_0 = 0x0123FEEDDEADBEEF0123FEEDDEADBEEF; TEMPLATE_WRITE high exactly one cycle; DONE exactly two cycles later.
- FF write: 0x02 plus 32 bytes; the controller model holds BRAM_READY low for 5 cycles after the strobe → WRITE_DATA_1 = the last 16 bytes; DONE only after BRAM_READY returns high; FF_WRITE pulses once.
- BRAM_READY = 0 when ISSUE is entered, for 4 cycles → INPUT_WRITE is delayed until BRAM_READY = 1 and is still one cycle wide.
- Command 0x07 → ERR pulse, ERR_CODE = 1, no strobe, RX_READY stays 1. Then 0x00 → no DONE, no ERR.
- TIMEOUT = 8, payload stalls after 3 bytes → ERR with ERR_CODE = 2 on the 8th idle cycle, no strobe. The next 0x03 command plus 16 bytes completes normally.
- RST_N pulsed low mid-payload → all outputs 0 asynchronously, no strobe.
- With BRAM_LOAD_SEQ_CHECKSUM_EN: a wrong checksum byte gives ERR with ERR_CODE = 3; the correct checksum gives a normal strobe and DONE.

Source files
------------

// File: rtl/bram_load_seq.sv
// bram_load_seq: decodes a host command byte, assembles a 128/256-bit payload MSB-first, issues one BRAM write strobe.
// Latency: strobe in the cycle after the last payload (or checksum) byte if READY is high; DONE two cycles after the strobe at the earliest.
// Backpressure: rx_ready is low from ISSUE until DONE; a low bram_ready stalls the strobe in ISSUE and DONE in WAIT_RDY.
// Optional feature: define BRAM_LOAD_SEQ_CHECKSUM_EN to require an XOR checksum byte after the payload.
module bram_load_seq #(
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    input  logic         bram_ready,
    output logic         template_write,
    output logic         ff_write,
    output logic         input_write,
    output logic [127:0] write_data_0,
    output logic [127:0] write_data_1,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [1:0]   err_code
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PAYLOAD  = 3'd1,
        S_ISSUE    = 3'd2,
        S_GAP      = 3'd3,
        S_WAIT_RDY = 3'd4
`ifdef BRAM_LOAD_SEQ_CHECKSUM_EN
        , S_CHECK  = 3'd5
`endif
    } state_t;

    // idle-cycle counter wide enough to hold TIMEOUT; TIMEOUT == 0 disables the abort
    localparam int             TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]  TO_LAST = (TIMEOUT > 1) ? TW'(TIMEOUT - 1) : '0;

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [4:0]     byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic [127:0]   wd0_q, wd0_d, wd1_q, wd1_d;
    logic [1:0]     err_code_q, err_code_d;
    logic           rx_ready_q, rx_ready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           tw_q, tw_d, fw_q, fw_d, iw_q, iw_d;
    logic           fire_d;
`ifdef BRAM_LOAD_SEQ_CHECKSUM_EN
    logic [7:0]     csum_q, csum_d;
`endif

    logic rx_fire;
    logic fire_q;
    logic last_byte;
    logic timeout_hit;

    assign rx_fire     = rx_valid & rx_ready_q;
    assign fire_q      = tw_q | fw_q | iw_q;
    assign last_byte   = (op_q == 2'b10) ? (byte_cnt_q == 5'd31) : (byte_cnt_q == 5'd15);
    // to_cnt holds the index of the current idle cycle, so the abort registers in time for ERR to show in cycle TIMEOUT
    assign timeout_hit = (TIMEOUT != 0) && (to_cnt_q >= TO_LAST);

    // next-state and next-output computation; every output is a flop loaded from here
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        byte_cnt_d = byte_cnt_q;
        to_cnt_d   = to_cnt_q;
        wd0_d      = wd0_q;
        wd1_d      = wd1_q;
        err_code_d = err_code_q;
        fire_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
`ifdef BRAM_LOAD_SEQ_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    if (rx_data[7:2] != 6'd0) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                    end else if (rx_data[1:0] != 2'b00) begin
                        op_d       = rx_data[1:0];
                        wd0_d      = '0;
                        wd1_d      = '0;
                        byte_cnt_d = '0;
                        to_cnt_d   = TW'(1);
                        state_d    = S_PAYLOAD;
`ifdef BRAM_LOAD_SEQ_CHECKSUM_EN
                        csum_d     = rx_data;
`endif
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_fire) begin
                    if (!byte_cnt_q[4]) wd0_d = {wd0_q[119:0], rx_data};
                    else                wd1_d = {wd1_q[119:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 5'd1;
                    to_cnt_d   = TW'(1);
`ifdef BRAM_LOAD_SEQ_CHECKSUM_EN
                    csum_d     = csum_q ^ rx_data;
                    if (last_byte) state_d = S_CHECK;
`else
                    if (last_byte) begin
                        state_d = S_ISSUE;
                        fire_d  = bram_ready;
                    end
`endif
                end else if (timeout_hit) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    state_d    = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
`ifdef BRAM_LOAD_SEQ_CHECKSUM_EN
            S_CHECK: begin
                if (rx_fire) begin
                    if (rx_data == csum_q) begin
                        state_d = S_ISSUE;
                        fire_d  = bram_ready;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'd3;
                        state_d    = S_IDLE;
                    end
                end else if (timeout_hit) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    state_d    = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
`endif
            S_ISSUE: begin
                // strobe is one cycle wide: once shown, move on; otherwise retry whenever READY is seen
                if (fire_q) state_d = S_GAP;
                else        fire_d  = bram_ready;
            end
            S_GAP: begin
                // READY during the strobe cycle is skipped; it is first sampled on the edge into WAIT_RDY
                state_d = S_WAIT_RDY;
                done_d  = bram_ready;
            end
            S_WAIT_RDY: begin
                if (done_q) state_d = S_IDLE;
                else        done_d  = bram_ready;
            end
            default: state_d = S_IDLE;
        endcase

        tw_d       = fire_d && (op_q == 2'b01);
        fw_d       = fire_d && (op_q == 2'b10);
        iw_d       = fire_d && (op_q == 2'b11);
        rx_ready_d = (state_d == S_IDLE) || (state_d == S_PAYLOAD)
`ifdef BRAM_LOAD_SEQ_CHECKSUM_EN
                     || (state_d == S_CHECK)
`endif
                     ;
        busy_d     = (state_d != S_IDLE);
    end

    // single state/output register bank; reset aborts any command with no strobe, DONE or ERR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= 2'b00;
            byte_cnt_q <= '0;
            to_cnt_q   <= '0;
            wd0_q      <= '0;
            wd1_q      <= '0;
            err_code_q <= 2'd0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tw_q       <= 1'b0;
            fw_q       <= 1'b0;
            iw_q       <= 1'b0;
`ifdef BRAM_LOAD_SEQ_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            byte_cnt_q <= byte_cnt_d;
            to_cnt_q   <= to_cnt_d;
            wd0_q      <= wd0_d;
            wd1_q      <= wd1_d;
            err_code_q <= err_code_d;
            rx_ready_q <= rx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tw_q       <= tw_d;
            fw_q       <= fw_d;
            iw_q       <= iw_d;
`ifdef BRAM_LOAD_SEQ_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign rx_ready       = rx_ready_q;
    assign template_write = tw_q;
    assign ff_write       = fw_q;
    assign input_write    = iw_q;
    assign write_data_0   = wd0_q;
    assign write_data_1   = wd1_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign err_code       = err_code_q;

endmodule

// File: tb/tb_bram_load_seq.sv
// tb_bram_load_seq: drives host byte streams into bram_load_seq and scoreboards strobes, payload words and error codes.
// Latency: strobe/DONE/ERR timing checked relative to stimulus and to the controller READY model.
// Backpressure: controller model can hold READY low for a fixed time after a strobe, or be driven by hand.
module tb_bram_load_seq;

    logic         clk;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic         bram_ready;
    logic         template_write, ff_write, input_write;
    logic [127:0] write_data_0, write_data_1;
    logic         busy, done, err;
    logic [1:0]   err_code;

    bram_load_seq #(.TIMEOUT(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .bram_ready     (bram_ready),
        .template_write (template_write),
        .ff_write       (ff_write),
        .input_write    (input_write),
        .write_data_0   (write_data_0),
        .write_data_1   (write_data_1),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .err_code       (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   kind;
        logic [127:0] w0;
        logic [127:0] w1;
    } wr_t;

    wr_t        exp_wr[$];
    logic [1:0] exp_err[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int strobe_cnt = 0, done_cnt = 0, err_cnt = 0;
    int strobe_cyc = 0, done_cyc = 0, err_cyc = 0;
    logic prev_any = 1'b0;

    // controller model: READY is either driven by hand or dropped for drop_len samples after each strobe
    logic manual = 1'b0;
    logic man_rdy = 1'b1;
    logic ctl_rdy = 1'b1;
    int   drop_len = 0;
    int   hold = 0;
    assign bram_ready = manual ? man_rdy : ctl_rdy;

    logic [7:0] pl [32];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (hold > 0) begin
                ctl_rdy = 1'b0;
                hold--;
            end else begin
                ctl_rdy = 1'b1;
            end
            if ((template_write | ff_write | input_write) && drop_len > 0) begin
                ctl_rdy = 1'b0;
                hold = drop_len - 1;
            end
        end
    end

    // monitor: pops the scoreboard on every strobe and ERR, counts DONE pulses
    initial begin
        wr_t        e;
        logic       any;
        logic [1:0] kind;
        logic [1:0] ec;
        forever begin
            @(negedge clk);
            any = template_write | ff_write | input_write;
            if (any) begin
                chk("strobe_onehot", $countones({template_write, ff_write, input_write}), 1);
                chk("strobe_width", prev_any, 0);
                chk("strobe_expected", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    kind = template_write ? 2'd1 : (ff_write ? 2'd2 : 2'd3);
                    chk("strobe_kind", kind, e.kind);
                    chk("write_data_0", write_data_0, e.w0);
                    chk("write_data_1", write_data_1, e.w1);
                end
                strobe_cnt++;
                strobe_cyc = cyc;
            end
            prev_any = any;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
                chk("err_expected", exp_err.size() != 0, 1);
                if (exp_err.size() != 0) begin
                    ec = exp_err.pop_front();
                    chk("err_code", err_code, ec);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int g;
        rx_data = b;
        rx_valid = 1'b1;
        g = 0;
        while (!rx_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk("rx_ready_wait", rx_ready, 1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] cmd, input int n, input bit bad_csum);
        logic [7:0] cs;
        cs = cmd;
        send_byte(cmd);
        for (int i = 0; i < n; i++) begin
            send_byte(pl[i]);
            cs = cs ^ pl[i];
        end
`ifdef BRAM_LOAD_SEQ_CHECKSUM_EN
        send_byte(bad_csum ? (cs ^ 8'h5a) : cs);
`else
        if (bad_csum) cs = ~cs;
`endif
    endtask

    function automatic logic [127:0] word_of(input int base);
        logic [127:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) w = {w[119:0], pl[base + i]};
        return w;
    endfunction

    task automatic wait_done(input int target);
        int g;
        g = 0;
        while (done_cnt < target && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("done_seen", done_cnt >= target, 1);
    endtask

    task automatic push_wr(input logic [1:0] k, input logic [127:0] w0, input logic [127:0] w1);
        wr_t e;
        e.kind = k;
        e.w0 = w0;
        e.w1 = w1;
        exp_wr.push_back(e);
    endtask

    initial begin
        logic [7:0] pat [8];
        int s0, d0, e0, t0, rel;
        pat = '{8'h01, 8'h23, 8'hFE, 8'hED, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        rst_n = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {template_write, ff_write, input_write, done, err}, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_wdata", {write_data_0, write_data_1}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rx_ready_after_reset", rx_ready, 1);

        // template write with READY held high
        for (int i = 0; i < 16; i++) pl[i] = pat[i % 8];
        push_wr(2'd1, 128'h0123FEEDDEADBEEF0123FEEDDEADBEEF, 128'h0);
        s0 = strobe_cnt;
        d0 = done_cnt;
        send_cmd(8'h01, 16, 1'b0);
        wait_done(d0 + 1);
        chk("tmpl_done_gap", done_cyc - strobe_cyc, 2);
        chk("tmpl_one_strobe", strobe_cnt - s0, 1);
        chk("tmpl_hold", write_data_0, 128'h0123FEEDDEADBEEF0123FEEDDEADBEEF);

        // FF write, controller drops READY for 5 samples after the strobe
        for (int i = 0; i < 32; i++) pl[i] = 8'(i * 13 + 5);
        push_wr(2'd2, word_of(0), word_of(16));
        drop_len = 5;
        s0 = strobe_cnt;
        d0 = done_cnt;
        send_cmd(8'h02, 32, 1'b0);
        wait_done(d0 + 1);
        chk("ff_done_gap", done_cyc - strobe_cyc, 6);
        chk("ff_one_strobe", strobe_cnt - s0, 1);
        chk("ff_wdata_1", write_data_1, word_of(16));
        drop_len = 0;
        repeat (3) @(negedge clk);

        // input write with READY low as ISSUE is entered, for 4 cycles
        for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(0, 255));
        push_wr(2'd3, word_of(0), 128'h0);
        manual = 1'b1;
        man_rdy = 1'b0;
        s0 = strobe_cnt;
        d0 = done_cnt;
        send_cmd(8'h03, 16, 1'b0);
        repeat (3) @(negedge clk);
        chk("in_no_early_strobe", strobe_cnt - s0, 0);
        man_rdy = 1'b1;
        rel = cyc;
        wait_done(d0 + 1);
        chk("in_strobe_after_ready", strobe_cyc - rel, 1);
        chk("in_one_strobe", strobe_cnt - s0, 1);
        manual = 1'b0;
        repeat (2) @(negedge clk);

        // bad opcode then NOP
        e0 = err_cnt;
        s0 = strobe_cnt;
        exp_err.push_back(2'd1);
        send_byte(8'h07);
        @(negedge clk);
        chk("bad_rx_ready", rx_ready, 1);
        chk("bad_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("bad_err_pulse", err_cnt - e0, 1);
        d0 = done_cnt;
        send_byte(8'h00);
        repeat (4) @(negedge clk);
        chk("nop_no_done", done_cnt - d0, 0);
        chk("nop_no_err", err_cnt - e0, 1);
        chk("nop_busy", busy, 0);
        chk("bad_no_strobe", strobe_cnt - s0, 0);

        // payload stall after 3 bytes: ERR code 2 in the 8th idle cycle
        e0 = err_cnt;
        s0 = strobe_cnt;
        exp_err.push_back(2'd2);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        t0 = cyc;
        for (int g = 0; g < 30 && err_cnt == e0; g++) @(negedge clk);
        chk("to_err_seen", err_cnt - e0, 1);
        chk("to_err_cycle", err_cyc - t0, 7);
        chk("to_no_strobe", strobe_cnt - s0, 0);
        chk("to_busy", busy, 0);
        for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(0, 255));
        push_wr(2'd3, word_of(0), 128'h0);
        d0 = done_cnt;
        send_cmd(8'h03, 16, 1'b0);
        wait_done(d0 + 1);
        chk("to_recover_strobe", strobe_cnt - s0, 1);

`ifdef BRAM_LOAD_SEQ_CHECKSUM_EN
        // checksum mismatch, then a matching checksum
        e0 = err_cnt;
        s0 = strobe_cnt;
        exp_err.push_back(2'd3);
        send_cmd(8'h01, 16, 1'b1);
        repeat (3) @(negedge clk);
        chk("cs_err_pulse", err_cnt - e0, 1);
        chk("cs_no_strobe", strobe_cnt - s0, 0);
        push_wr(2'd1, word_of(0), 128'h0);
        d0 = done_cnt;
        send_cmd(8'h01, 16, 1'b0);
        wait_done(d0 + 1);
        chk("cs_ok_strobe", strobe_cnt - s0, 1);
`endif

        // reset mid-payload
        s0 = strobe_cnt;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'h02);
        for (int i = 0; i < 5; i++) send_byte(8'(i + 1));
        chk("mid_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rx_ready", rx_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_wdata_0", write_data_0, 0);
        chk("arst_err_code", err_code, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_rx_ready_back", rx_ready, 1);
        repeat (10) @(negedge clk);
        chk("arst_no_strobe", strobe_cnt - s0, 0);
        chk("arst_no_done", done_cnt - d0, 0);
        chk("arst_no_err", err_cnt - e0, 0);

        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("err_queue_empty", exp_err.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
